// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the RV32 instruction-fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_pc_pipe_flopenrc.sv
// flopenrc: register with async active-low reset, enable and synchronous clear.
module flopenrc #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  // Clear outranks enable so a flush beats a stall.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_q <= RST_VAL;
    else if (i_clr) o_q <= CLR_VAL;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/fetch_pc_pipe.sv
// fetch_pc_pipe: PC register, PC+4 adder, next-PC mux and IF/ID register.
// Define IFETCH_HAZARD_EN to honour StallF/StallD/FlushD; otherwise they are ignored.
module fetch_pc_pipe
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] InstrF,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);
  localparam logic [3*XLEN-1:0] D_INIT = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};
  logic [XLEN-1:0] w_pc_next;
  logic w_pc_en, w_d_en, w_d_clr;
`ifdef IFETCH_HAZARD_EN
  assign w_pc_en = PCSrcE | ~StallF;
  assign w_d_en = ~StallD;
  assign w_d_clr = FlushD;
`else
  logic w_unused;
  assign w_unused = StallF ^ StallD ^ FlushD;
  assign w_pc_en = 1'b1;
  assign w_d_en = 1'b1;
  assign w_d_clr = 1'b0;
`endif
  assign PCPlus4F = PCF + 32'd4;
  assign w_pc_next = PCSrcE ? PCTargetE : PCPlus4F;
  flopenrc #(.W(XLEN), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(reset), .i_en(w_pc_en), .i_clr(1'b0),
    .i_d(w_pc_next), .o_q(PCF)
  );
  flopenrc #(.W(3*XLEN), .RST_VAL(D_INIT), .CLR_VAL(D_INIT)) u_ifid (
    .clk(clk), .rst_n(reset), .i_en(w_d_en), .i_clr(w_d_clr),
    .i_d({InstrF, PCF, PCPlus4F}), .o_q({InstrD, PCD, PCPlus4D})
  );
endmodule

// File: tb/tb_fetch_pc_pipe.sv
// tb_fetch_pc_pipe: directed self-checking bench for fetch_pc_pipe.
module tb_fetch_pc_pipe;
  logic clk = 1'b0;
  logic reset, PCSrcE, StallF, StallD, FlushD, use_force;
  logic [31:0] PCTargetE, InstrF, force_instr;
  logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  int errors = 0;
  int checks = 0;

  fetch_pc_pipe dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrF(InstrF), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign InstrF = use_force ? force_instr : imem(PCF);

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rst_pcf got=%h exp=%h", PCF, 32'h0); end
    checks++; if (InstrD !== 32'h13) begin errors++; $display("FAIL rst_instrd got=%h exp=%h", InstrD, 32'h13); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd got=%h exp=%h", PCD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pcplus4d got=%h exp=%h", PCPlus4D, 32'h0); end
    reset = 1'b1;
    #1;
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL rst_pcplus4f got=%h exp=%h", PCPlus4F, 32'h4); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (PCF !== 32'(4*i)) begin errors++; $display("FAIL seq_pcf[%0d] got=%h exp=%h", i, PCF, 32'(4*i)); end
      checks++; if (PCD !== 32'(4*(i-1))) begin errors++; $display("FAIL seq_pcd[%0d] got=%h exp=%h", i, PCD, 32'(4*(i-1))); end
      checks++; if (PCPlus4D !== 32'(4*i)) begin errors++; $display("FAIL seq_pcplus4d[%0d] got=%h exp=%h", i, PCPlus4D, 32'(4*i)); end
      checks++; if (InstrD !== imem(32'(4*(i-1)))) begin errors++; $display("FAIL seq_instrd[%0d] got=%h exp=%h", i, InstrD, imem(32'(4*(i-1)))); end
    end
  endtask

  task automatic test_redirect;
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    @(negedge clk);
    PCSrcE = 1'b0;
    checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL redir_pcf got=%h exp=%h", PCF, 32'h40); end
    checks++; if (PCD !== 32'hC) begin errors++; $display("FAIL redir_pcd got=%h exp=%h", PCD, 32'hC); end
    checks++; if (InstrD !== imem(32'hC)) begin errors++; $display("FAIL redir_instrd got=%h exp=%h", InstrD, imem(32'hC)); end
    @(negedge clk);
    checks++; if (PCF !== 32'h44) begin errors++; $display("FAIL redir_pcf2 got=%h exp=%h", PCF, 32'h44); end
    checks++; if (PCD !== 32'h40) begin errors++; $display("FAIL redir_pcd2 got=%h exp=%h", PCD, 32'h40); end
    checks++; if (PCPlus4D !== 32'h44) begin errors++; $display("FAIL redir_pcplus4d2 got=%h exp=%h", PCPlus4D, 32'h44); end
  endtask

  task automatic test_async_reset;
    #2 reset = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL arst_pcf got=%h exp=%h", PCF, 32'h0); end
    checks++; if (InstrD !== 32'h13) begin errors++; $display("FAIL arst_instrd got=%h exp=%h", InstrD, 32'h13); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL arst_pcd got=%h exp=%h", PCD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL arst_pcplus4d got=%h exp=%h", PCPlus4D, 32'h0); end
    @(negedge clk);
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL arst_hold_pcf got=%h exp=%h", PCF, 32'h0); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL arst_rel_pcf got=%h exp=%h", PCF, 32'h4); end
    checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL arst_rel_pcplus4d got=%h exp=%h", PCPlus4D, 32'h4); end
  endtask

  task automatic test_wrap;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    @(negedge clk);
    PCSrcE = 1'b0;
    checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcf got=%h exp=%h", PCF, 32'hFFFF_FFFC); end
    checks++; if (PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4f got=%h exp=%h", PCPlus4F, 32'h0); end
    @(negedge clk);
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_next_pcf got=%h exp=%h", PCF, 32'h0); end
    checks++; if (PCD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcd got=%h exp=%h", PCD, 32'hFFFF_FFFC); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4d got=%h exp=%h", PCPlus4D, 32'h0); end
  endtask

`ifdef IFETCH_HAZARD_EN
  task automatic test_stall;
    PCSrcE = 1'b1; PCTargetE = 32'h8;
    @(negedge clk);
    PCSrcE = 1'b0; StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL stall_pcf[%0d] got=%h exp=%h", i, PCF, 32'h8); end
      checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL stall_pcd[%0d] got=%h exp=%h", i, PCD, 32'h0); end
      checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL stall_pcplus4d[%0d] got=%h exp=%h", i, PCPlus4D, 32'h4); end
      checks++; if (InstrD !== imem(32'h0)) begin errors++; $display("FAIL stall_instrd[%0d] got=%h exp=%h", i, InstrD, imem(32'h0)); end
    end
    StallF = 1'b0; StallD = 1'b0;
    @(negedge clk);
    checks++; if (PCF !== 32'hC) begin errors++; $display("FAIL stall_rel_pcf got=%h exp=%h", PCF, 32'hC); end
    checks++; if (PCD !== 32'h8) begin errors++; $display("FAIL stall_rel_pcd got=%h exp=%h", PCD, 32'h8); end
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h80;
    @(negedge clk);
    StallF = 1'b0; PCSrcE = 1'b0;
    checks++; if (PCF !== 32'h80) begin errors++; $display("FAIL stall_redir_pcf got=%h exp=%h", PCF, 32'h80); end
  endtask

  task automatic test_flush;
    use_force = 1'b1; force_instr = 32'h0050_0093;
    @(negedge clk);
    checks++; if (InstrD !== 32'h0050_0093) begin errors++; $display("FAIL flush_load got=%h exp=%h", InstrD, 32'h0050_0093); end
    FlushD = 1'b1;
    @(negedge clk);
    checks++; if (InstrD !== 32'h13) begin errors++; $display("FAIL flush_instrd got=%h exp=%h", InstrD, 32'h13); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL flush_pcd got=%h exp=%h", PCD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL flush_pcplus4d got=%h exp=%h", PCPlus4D, 32'h0); end
    FlushD = 1'b0;
    @(negedge clk);
    checks++; if (InstrD !== 32'h0050_0093) begin errors++; $display("FAIL flush_reload got=%h exp=%h", InstrD, 32'h0050_0093); end
    FlushD = 1'b1; StallD = 1'b1;
    @(negedge clk);
    checks++; if (InstrD !== 32'h13) begin errors++; $display("FAIL flush_stall_instrd got=%h exp=%h", InstrD, 32'h13); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL flush_stall_pcd got=%h exp=%h", PCD, 32'h0); end
    FlushD = 1'b0; StallD = 1'b0; use_force = 1'b0;
  endtask
`else
  task automatic test_no_hazard;
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    @(negedge clk);
    PCSrcE = 1'b0; StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
    @(negedge clk);
    checks++; if (PCF !== 32'h104) begin errors++; $display("FAIL nohz_pcf got=%h exp=%h", PCF, 32'h104); end
    checks++; if (PCD !== 32'h100) begin errors++; $display("FAIL nohz_pcd got=%h exp=%h", PCD, 32'h100); end
    checks++; if (InstrD !== imem(32'h100)) begin errors++; $display("FAIL nohz_instrd got=%h exp=%h", InstrD, imem(32'h100)); end
    checks++; if (PCPlus4D !== 32'h104) begin errors++; $display("FAIL nohz_pcplus4d got=%h exp=%h", PCPlus4D, 32'h104); end
    @(negedge clk);
    checks++; if (PCF !== 32'h108) begin errors++; $display("FAIL nohz_pcf2 got=%h exp=%h", PCF, 32'h108); end
    checks++; if (PCD !== 32'h104) begin errors++; $display("FAIL nohz_pcd2 got=%h exp=%h", PCD, 32'h104); end
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0;
    FlushD = 1'b0; use_force = 1'b0; force_instr = '0;
    test_reset;
    test_redirect;
    test_async_reset;
    test_wrap;
`ifdef IFETCH_HAZARD_EN
    test_stall;
    test_flush;
`else
    test_no_hazard;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
